mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the 8-bit computer's 256x8 main memory. It sits between the instruction-fetch unit (port F, read-only) and the load/store unit (port D, read/write) and the single address/data interface of the memory array. It grants one access at a time, round-robin, and inserts a programmable number of wait states. It returns registered read data with a one-cycle ack pulse.

## Interface
- AW, 8, address width; the memory holds 2^AW words.
- DW, 8, data width.
- WAIT_CYCLES, 1, number of extra clocks the memory address is held before data is captured (0..15).

Ports:
- clk  in  1  system clock; the block uses one clock only.
- rst_n  in  1  reset, asynchronous and active-low.
- f_req  in  1  fetch request; held high, with f_addr stable, until f_ack.
- f_addr  in  AW  fetch address.
- f_ack  out  1  one-cycle pulse: f_rdata valid.
- f_rdata  out  DW  fetch read data; registered, held until the next f_ack.
- d_req  in  1  data-port request; held high, with d_we/d_addr/d_wdata stable, until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data-port address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle pulse: access complete; d_rdata valid for reads.
- d_rdata  out  DW  data-port read data; registered, unchanged by writes.
- mem_addr  out  AW  address to the memory array (registered).
- mem_we  out  1  write strobe to the memory array.
- mem_wdata  out  DW  write data to the memory array.
- mem_rdata  in  DW  combinational read data from the memory array.
- busy  out  1  high while in ACCESS.

## Operation
- States: IDLE and ACCESS. Internal registers: owner (0 = F, 1 = D), last (last granted port), cnt (4 bits).
- In IDLE, on a clock edge with any request high:
  - Pick the winner.
  - Load mem_addr, mem_wdata and mem_we from the winner; mem_we is d_we for port D and 0 for port F.
  - Set owner to the winner, cnt to WAIT_CYCLES and last to the winner, then go to ACCESS.
- Arbitration:
  - A lone requester always wins.
  - If both requests are high, the winner is the port not equal to last (round-robin).
- In ACCESS, on each edge:
  - If cnt != 0, decrement cnt.
  - If cnt == 0:
    - For a read, capture mem_rdata into the owner's rdata register.
    - Pulse the owner's ack, drop mem_we, and go to IDLE.
- Writes: mem_we is high for the whole ACCESS state. The memory commits at the edge that leaves ACCESS.
- The non-owner's request is ignored during ACCESS. It is re-evaluated in IDLE.
- A requester may keep req high after ack; this is a new back-to-back request. IDLE samples it on the edge where ack falls.
- mem_addr and mem_wdata hold their last values in IDLE. mem_we is 0 in IDLE.
- Reset values: state IDLE, last = 1 (F wins the first contention), cnt 0, all outputs 0.
- Reset mid-access aborts the access immediately: mem_we drops asynchronously, no ack is issued, and rdata is cleared.

## Timing
- Latency from the sampling edge in IDLE to the edge that raises ack is WAIT_CYCLES+1 clocks.
- ack is high for exactly one cycle.
- Sustained throughput is one access per WAIT_CYCLES+2 clocks.
- rdata changes only on the edge that raises the matching ack.
- f_ack and d_ack are never high in the same cycle.
- mem_addr is stable for all WAIT_CYCLES+1 cycles of ACCESS.
- With WAIT_CYCLES = 0, ACCESS lasts exactly one cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS)
  - the port-index constants (PORT_F = 0, PORT_D = 1)
  - the AW/DW defaults
- Sub-module rr_arb2 is the two-way round-robin picker. It is combinational, taking req[1:0] and last and returning the winner plus a valid flag. It is reusable by future bus arbiters.
- The FSM, counter and data registers live in mem_arbiter.

## Test plan
- Fetch read, WAIT_CYCLES=1: preload mem[0x02] = 0x5A, f_req with f_addr=0x02 → f_ack 2 clocks after the sampling edge, f_rdata=0x5A; d_ack stays 0.
- Data write then read: d_we=1, d_addr=0x10, d_wdata=0xC3 → mem_we high for 2 cycles, d_ack pulses, d_rdata unchanged. Then d_we=0 on 0x10 → d_rdata=0xC3.
- Contention out of reset: f_req and d_req held high together → grants alternate F, D, F, D. Each ack arrives 3 clocks apart; never both acks in one cycle.
- Back-to-back: f_req held high across 4 accesses with WAIT_CYCLES=0 → f_ack every 2nd clock and mem_addr updates each access.
- Reset mid-access: assert rst_n=0 one cycle into a write ACCESS → mem_we=0 immediately, no d_ack, busy=0. After release, the first contention is granted to F.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;
   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;

   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic {IDLE, ACCESS} state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-array signals of the arbiter, grouped as one bus.
interface mem_arbiter_if #(
   parameter int AW = mem_arb_pkg::AW_DEF,
   parameter int DW = mem_arb_pkg::DW_DEF
);
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_ack;
   logic [DW-1:0] f_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata, busy
   );
   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       gnt_o,
   output logic       vld_o
);
   assign vld_o = |req_i;
   assign gnt_o = (&req_i) ? ~last_i : req_i[1];
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (F) and load/store (D) ports onto one memory array,
// holding each access for WAIT_CYCLES+1 clocks before acking.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int AW          = AW_DEF,
   parameter int DW          = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);
   state_e        state_q;
   logic          owner_q, last_q;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] mem_addr_q;
   logic          mem_we_q;
   logic [DW-1:0] mem_wdata_q, f_rdata_q, d_rdata_q;
   logic          f_ack_q, d_ack_q;
   logic          win, win_vld;

   rr_arb2 u_pick (
      .req_i  ({bus.d_req, bus.f_req}),
      .last_i (last_q),
      .gnt_o  (win),
      .vld_o  (win_vld)
   );

   assign cnt_d = cnt_q - 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= PORT_F;
         last_q      <= PORT_D;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         f_rdata_q   <= '0;
         d_rdata_q   <= '0;
         f_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
      end else begin
         f_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state_q)
            IDLE: if (win_vld) begin
               owner_q <= win;
               last_q  <= win;
               cnt_q   <= 4'(WAIT_CYCLES);
               state_q <= ACCESS;
               if (win == PORT_D) begin
                  mem_addr_q  <= bus.d_addr;
                  mem_wdata_q <= bus.d_wdata;
                  mem_we_q    <= bus.d_we;
               end else begin
                  mem_addr_q  <= bus.f_addr;
                  mem_we_q    <= 1'b0;
               end
            end
            ACCESS: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_d;
               end else begin
                  // A write commits in the memory on this same edge.
                  if (!mem_we_q) begin
                     if (owner_q == PORT_D) d_rdata_q <= bus.mem_rdata;
                     else                   f_rdata_q <= bus.mem_rdata;
                  end
                  f_ack_q  <= (owner_q == PORT_F);
                  d_ack_q  <= (owner_q == PORT_D);
                  mem_we_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.f_ack     = f_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.f_rdata   = f_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = (state_q == ACCESS);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on a WAIT_CYCLES=1 and a
// WAIT_CYCLES=0 instance, plus random traffic against a transaction model.
module tb_mem_arbiter;
   localparam int W1 = 1;
   localparam int W0 = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [7:0] f_addr = '0, d_addr = '0, d_wdata = '0;
   logic       pl_en = 1'b0;
   logic [7:0] pl_addr = '0, pl_data = '0;
   logic [7:0] mem1 [256];
   logic [7:0] mem0 [256];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   mem_arbiter_if b1 ();
   mem_arbiter_if b0 ();

   mem_arbiter #(.WAIT_CYCLES(W1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   mem_arbiter #(.WAIT_CYCLES(W0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

   assign b1.f_req = f_req;   assign b0.f_req = f_req;
   assign b1.f_addr = f_addr; assign b0.f_addr = f_addr;
   assign b1.d_req = d_req;   assign b0.d_req = d_req;
   assign b1.d_we = d_we;     assign b0.d_we = d_we;
   assign b1.d_addr = d_addr; assign b0.d_addr = d_addr;
   assign b1.d_wdata = d_wdata; assign b0.d_wdata = d_wdata;
   assign b1.mem_rdata = mem1[b1.mem_addr];
   assign b0.mem_rdata = mem0[b0.mem_addr];

   always @(posedge clk) begin
      if (pl_en) begin
         mem1[pl_addr] <= pl_data;
         mem0[pl_addr] <= pl_data;
      end else begin
         if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
         if (b0.mem_we) mem0[b0.mem_addr] <= b0.mem_wdata;
      end
   end

   task automatic do_reset();
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = v;
      @(negedge clk); pl_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({b1.f_ack, b1.d_ack, b1.mem_we, b1.busy} !== 4'b0) begin
         errors++; $display("FAIL reset_ctl got %b want 0000", {b1.f_ack, b1.d_ack, b1.mem_we, b1.busy});
      end
      checks++;
      if ({b1.f_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata} !== 32'h0) begin
         errors++; $display("FAIL reset_data got %h want 0", {b1.f_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata});
      end
   endtask

   task automatic test_fetch_read();
      int lat = -1, dacks = 0, addr_bad = 0;
      do_reset();
      preload(8'h02, 8'h5A);
      @(negedge clk); f_req = 1'b1; f_addr = 8'h02;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (b1.d_ack) dacks++;
         if (b1.busy && b1.mem_addr !== 8'h02) addr_bad++;
         if (b1.f_ack && lat < 0) begin lat = n; f_req = 1'b0; end
      end
      checks++;
      if (lat != W1 + 1) begin errors++; $display("FAIL fetch_latency got %0d want %0d", lat, W1 + 1); end
      checks++;
      if (b1.f_rdata !== 8'h5A) begin errors++; $display("FAIL fetch_rdata got %h want 5a", b1.f_rdata); end
      checks++;
      if (dacks != 0) begin errors++; $display("FAIL fetch_no_dack got %0d want 0", dacks); end
      checks++;
      if (addr_bad != 0) begin errors++; $display("FAIL fetch_addr_hold got %0d bad want 0", addr_bad); end
   endtask

   task automatic test_write_read();
      int lat = -1, we_cyc = 0;
      do_reset();
      @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'hC3;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (b1.mem_we) we_cyc++;
         if (b1.d_ack && lat < 0) begin lat = n; d_req = 1'b0; end
      end
      checks++;
      if (we_cyc != W1 + 1) begin errors++; $display("FAIL write_we_cycles got %0d want %0d", we_cyc, W1 + 1); end
      checks++;
      if (lat != W1 + 1) begin errors++; $display("FAIL write_latency got %0d want %0d", lat, W1 + 1); end
      checks++;
      if (b1.d_rdata !== 8'h00) begin errors++; $display("FAIL write_rdata_kept got %h want 00", b1.d_rdata); end
      lat = -1;
      @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (b1.d_ack && lat < 0) begin lat = n; d_req = 1'b0; end
      end
      checks++;
      if (lat != W1 + 1 || b1.d_rdata !== 8'hC3) begin
         errors++; $display("FAIL readback got lat %0d data %h want lat %0d data c3", lat, b1.d_rdata, W1 + 1);
      end
   endtask

   task automatic test_contention();
      int k = 0, both = 0;
      int at [4];
      logic prt [4];
      do_reset();
      @(negedge clk); f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 8'h01; d_addr = 8'h02;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (b1.f_ack && b1.d_ack) both++;
         if ((b1.f_ack || b1.d_ack) && k < 4) begin at[k] = n; prt[k] = b1.d_ack; k++; end
      end
      f_req = 1'b0; d_req = 1'b0;
      checks++;
      if (k != 4) begin errors++; $display("FAIL cont_count got %0d want 4", k); end
      else begin
         checks++;
         if ({prt[0], prt[1], prt[2], prt[3]} !== 4'b0101) begin
            errors++; $display("FAIL cont_order got %b want 0101", {prt[0], prt[1], prt[2], prt[3]});
         end
         checks++;
         if (at[0] != W1 + 1 || at[1] - at[0] != W1 + 2 || at[2] - at[1] != W1 + 2 || at[3] - at[2] != W1 + 2) begin
            errors++; $display("FAIL cont_spacing got %0d %0d %0d %0d want step %0d", at[0], at[1], at[2], at[3], W1 + 2);
         end
      end
      checks++;
      if (both != 0) begin errors++; $display("FAIL cont_dual_ack got %0d want 0", both); end
   endtask

   task automatic test_back_to_back();
      int k = 0, busy_cyc = 0, addr_bad = 0;
      int at [4];
      do_reset();
      @(negedge clk); f_req = 1'b1; f_addr = 8'h20;
      for (int n = 0; n < 14; n++) begin
         @(negedge clk);
         if (b0.busy) begin
            busy_cyc++;
            if (b0.mem_addr !== f_addr) addr_bad++;
         end
         if (b0.f_ack && k < 4) begin
            at[k] = n; k++;
            if (k == 4) f_req = 1'b0; else f_addr = f_addr + 8'd1;
         end
      end
      checks++;
      if (k != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", k); end
      else begin
         checks++;
         if (at[0] != 1 || at[1] != 3 || at[2] != 5 || at[3] != 7) begin
            errors++; $display("FAIL b2b_timing got %0d %0d %0d %0d want 1 3 5 7", at[0], at[1], at[2], at[3]);
         end
      end
      checks++;
      if (busy_cyc != 4) begin errors++; $display("FAIL b2b_access_len got %0d want 4", busy_cyc); end
      checks++;
      if (addr_bad != 0) begin errors++; $display("FAIL b2b_mem_addr got %0d bad want 0", addr_bad); end
   endtask

   task automatic test_reset_mid();
      int lat = -1, dacks = 0, first = -1;
      do_reset();
      preload(8'h31, 8'h66);
      preload(8'h30, 8'h11);
      @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 8'h31;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (b1.d_ack && lat < 0) begin lat = n; d_req = 1'b0; end
      end
      checks++;
      if (b1.d_rdata !== 8'h66) begin errors++; $display("FAIL mid_preread got %h want 66", b1.d_rdata); end
      @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 8'h77;
      @(negedge clk);
      checks++;
      if ({b1.busy, b1.mem_we} !== 2'b11) begin errors++; $display("FAIL mid_in_access got %b want 11", {b1.busy, b1.mem_we}); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({b1.mem_we, b1.busy, b1.d_ack} !== 3'b000 || b1.d_rdata !== 8'h00) begin
         errors++; $display("FAIL mid_abort got we/busy/ack %b rdata %h want 000 00", {b1.mem_we, b1.busy, b1.d_ack}, b1.d_rdata);
      end
      d_req = 1'b0; d_we = 1'b0;
      repeat (2) begin @(negedge clk); if (b1.d_ack) dacks++; end
      rst_n = 1'b1;
      checks++;
      if (dacks != 0 || mem1[8'h30] !== 8'h11) begin
         errors++; $display("FAIL mid_no_commit got acks %0d mem %h want 0 11", dacks, mem1[8'h30]);
      end
      @(negedge clk); f_req = 1'b1; d_req = 1'b1; f_addr = 8'h01; d_addr = 8'h02;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (first < 0 && b1.f_ack) first = 0;
         else if (first < 0 && b1.d_ack) first = 1;
      end
      f_req = 1'b0; d_req = 1'b0;
      checks++;
      if (first != 0) begin errors++; $display("FAIL mid_first_grant got %0d want 0", first); end
   endtask

   // Transaction model: an access is granted at the first edge the arbiter is
   // free with a request present, acks WAIT_CYCLES+1 edges later, and ties
   // go to the port not granted last.
   task automatic test_random();
      int         cyc = 0, ack_at = -1, own = 0, last = 1;
      logic       ef, ed, ebusy, g_we = 1'b0;
      logic [7:0] g_addr = '0, g_wdata = '0, exp_frd = '0, exp_drd = '0;
      logic [7:0] shadow [16];
      do_reset();
      for (int i = 0; i < 16; i++) begin
         shadow[i] = 8'($urandom);
         preload(8'(i), shadow[i]);
      end
      for (int it = 0; it < 400; it++) begin
         @(posedge clk); cyc++;
         if (ack_at < 0 && (f_req || d_req)) begin
            own = (f_req && d_req) ? 1 - last : (d_req ? 1 : 0);
            last = own;
            ack_at = cyc + W1 + 1;
            g_addr = own ? d_addr : f_addr;
            g_we = own ? d_we : 1'b0;
            g_wdata = d_wdata;
         end
         ef = (cyc == ack_at) && (own == 0);
         ed = (cyc == ack_at) && (own == 1);
         if (cyc == ack_at) begin
            if (g_we) shadow[g_addr[3:0]] = g_wdata;
            else if (own == 0) exp_frd = shadow[g_addr[3:0]];
            else exp_drd = shadow[g_addr[3:0]];
            ack_at = -1;
         end
         ebusy = (ack_at >= 0);
         @(negedge clk);
         checks++;
         if ({b1.f_ack, b1.d_ack, b1.busy} !== {ef, ed, ebusy}) begin
            errors++; $display("FAIL rnd_ctl cyc %0d got %b want %b", cyc, {b1.f_ack, b1.d_ack, b1.busy}, {ef, ed, ebusy});
         end
         checks++;
         if (b1.f_rdata !== exp_frd || b1.d_rdata !== exp_drd) begin
            errors++; $display("FAIL rnd_rdata cyc %0d got %h/%h want %h/%h", cyc, b1.f_rdata, b1.d_rdata, exp_frd, exp_drd);
         end
         if (ebusy) begin
            checks++;
            if (b1.mem_addr !== g_addr || b1.mem_we !== g_we || (g_we && b1.mem_wdata !== g_wdata)) begin
               errors++; $display("FAIL rnd_membus cyc %0d got %h %b %h want %h %b %h", cyc, b1.mem_addr, b1.mem_we, b1.mem_wdata, g_addr, g_we, g_wdata);
            end
         end
         if (b1.f_ack || !f_req) begin
            f_req = ($urandom_range(3) != 0);
            f_addr = 8'($urandom_range(15));
         end
         if (b1.d_ack || !d_req) begin
            d_req = ($urandom_range(3) != 0);
            d_we = 1'($urandom_range(1));
            d_addr = 8'($urandom_range(15));
            d_wdata = 8'($urandom);
         end
      end
      f_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch_read();
      test_write_read();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
